// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
// Build option: MUL_RADIX4_EN retires two multiplier bits per cycle.
package mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam int unsigned MUL_DEFAULT_WIDTH = 32;

    // Cycles needed to retire a width-bit multiplier k bits at a time.
    function automatic int unsigned mul_iter_count(input int unsigned width, input int unsigned k);
        return (width + k - 1) / k;
    endfunction

endpackage

// File: rtl/seq_mul_pp.sv
// Partial-product select and add into one accumulator slice.
// Build option: MUL_RADIX4_EN selects among 0, A, 2A, 3A; otherwise 0 or A.
module seq_mul_pp #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned K     = 1
) (
    input  logic [WIDTH+K-1:0] acc_slice,
    input  logic [WIDTH-1:0]   a,
`ifdef MUL_RADIX4_EN
    input  logic [WIDTH+1:0]   a3,
`endif
    input  logic [K-1:0]       sel,
    output logic [WIDTH+K-1:0] sum_c
);

    localparam int unsigned SW = WIDTH + K;

    logic [SW-1:0] pp_c;

`ifdef MUL_RADIX4_EN
    always_comb begin
        pp_c = '0;
        case (sel)
            2'b01:   pp_c = SW'(a);
            2'b10:   pp_c = SW'({a, 1'b0});
            2'b11:   pp_c = SW'(a3);
            default: pp_c = '0;
        endcase
    end
`else
    always_comb begin
        pp_c = '0;
        if (sel[0]) begin
            pp_c = SW'(a);
        end
    end
`endif

    assign sum_c = acc_slice + pp_c;

endmodule

// File: rtl/karatsuba_seq_mul.sv
// Sequential unsigned multiplier with start-edge launch and sticky done.
// Build option: MUL_RADIX4_EN halves latency by retiring two bits per cycle.
module karatsuba_seq_mul
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done,
    output logic                 busy
);

`ifdef MUL_RADIX4_EN
    localparam int unsigned K = 2;
`else
    localparam int unsigned K = 1;
`endif
    localparam int unsigned N  = mul_iter_count(WIDTH, K);
    localparam int unsigned MW = N * K;
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned AW = PW + K;
    localparam int unsigned SW = WIDTH + K;
    localparam int unsigned IW = $clog2(N + 1);
    localparam int unsigned OW = $clog2(AW);

    state_t          state;
    logic            start_q;
    logic [WIDTH-1:0] a_q;
    logic [MW-1:0]   b_q;
`ifdef MUL_RADIX4_EN
    logic [WIDTH+1:0] a3_q;
`endif
    logic [AW-1:0]   acc;
    logic [IW-1:0]   iter;
    logic [OW-1:0]   off_q;

    logic            launch_c;
    logic [SW-1:0]   sum_c;
    logic [AW-1:0]   acc_next_c;

    assign launch_c = start & ~start_q;

    seq_mul_pp #(
        .WIDTH (WIDTH),
        .K     (K)
    ) u_pp (
        .acc_slice (acc[off_q +: SW]),
        .a         (a_q),
`ifdef MUL_RADIX4_EN
        .a3        (a3_q),
`endif
        .sel       (b_q[K-1:0]),
        .sum_c     (sum_c)
    );

    // Bits below the current offset are final and bits above the slice are still zero.
    always_comb begin
        acc_next_c = acc;
        acc_next_c[off_q +: SW] = sum_c;
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            start_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
`ifdef MUL_RADIX4_EN
            a3_q    <= '0;
`endif
            acc     <= '0;
            iter    <= '0;
            off_q   <= '0;
            product <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            start_q <= start;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (launch_c) begin
                        a_q   <= a;
                        b_q   <= MW'(b);
`ifdef MUL_RADIX4_EN
                        a3_q  <= (WIDTH + 2)'(a) + ((WIDTH + 2)'(a) << 1);
`endif
                        acc   <= '0;
                        iter  <= IW'(N);
                        off_q <= '0;
                        done  <= 1'b0;
                        busy  <= 1'b1;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    acc  <= acc_next_c;
                    b_q  <= b_q >> K;
                    iter <= iter - IW'(1);
                    if (iter == IW'(1)) begin
                        product <= acc_next_c[PW-1:0];
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= ST_DONE;
                    end else begin
                        off_q <= off_q + OW'(K);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_karatsuba_seq_mul.sv
// Scoreboard bench for karatsuba_seq_mul (WIDTH=32 random plus a WIDTH=33 directed case).
module tb_karatsuba_seq_mul;

`ifdef MUL_RADIX4_EN
    localparam int KR = 2;
`else
    localparam int KR = 1;
`endif
    localparam int N32 = (32 + KR - 1) / KR;
    localparam int N33 = (33 + KR - 1) / KR;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic [63:0] product;
    logic        done;
    logic        busy;

    logic        start33 = 1'b0;
    logic [32:0] a33 = '0;
    logic [32:0] b33 = '0;
    logic [65:0] product33;
    logic        done33;
    logic        busy33;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic done_prev = 1'b0;

    logic [63:0] exp_q[$];
    int          lat_q[$];

    karatsuba_seq_mul #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a_i), .b(b_i),
        .product(product), .done(done), .busy(busy)
    );

    karatsuba_seq_mul #(.WIDTH(33)) dut33 (
        .clk(clk), .rst_n(rst_n), .start(start33), .a(a33), .b(b33),
        .product(product33), .done(done33), .busy(busy33)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every rising done retires one scoreboard entry.
    always @(negedge clk) begin
        if (!rst_n) begin
            done_prev = 1'b0;
        end else begin
            if (done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_done", 72'(done), 72'(0));
                end else begin
                    logic [63:0] e;
                    int          l;
                    e = exp_q.pop_front();
                    l = lat_q.pop_front();
                    chk("product", 72'(product), 72'(e));
                    chk("latency", 72'(cyc - l), 72'(N32));
                    chk("busy_at_done", 72'(busy), 72'(0));
                end
            end
            done_prev = done;
        end
    end

    // Launch one operation; operands are scrambled right after the launch edge.
    task automatic start_op(input logic [31:0] av, input logic [31:0] bv, input int hold, input bit glitch);
        @(negedge clk);
        a_i = av;
        b_i = bv;
        start = 1'b1;
        exp_q.push_back(64'(av) * 64'(bv));
        @(negedge clk);
        lat_q.push_back(cyc);
        chk("busy_after_launch", 72'(busy), 72'(1));
        chk("done_after_launch", 72'(done), 72'(0));
        a_i = $urandom;
        b_i = $urandom;
        for (int i = 1; i < hold; i++) @(negedge clk);
        if (hold > N32 + 1) begin
            chk("done_held_with_start", 72'(done), 72'(1));
            chk("no_relaunch", 72'(busy), 72'(0));
        end
        start = 1'b0;
        if (glitch) begin
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < N32 + 6) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", 72'(done), 72'(1));
    endtask

    initial begin
        #2;
        chk("rst_product", 72'(product), 72'(0));
        chk("rst_done", 72'(done), 72'(0));
        chk("rst_busy", 72'(busy), 72'(0));
        chk("rst_product33", 72'(product33), 72'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Full-scale operands.
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b0);
        wait_done();
        chk("fullscale_product", 72'(product), 72'(64'hFFFF_FFFE_0000_0001));

        // Middle-term width.
        begin
            int c0;
            int n;
            @(negedge clk);
            a33 = 33'h1_FFFF_FFFF;
            b33 = 33'h1_FFFF_FFFF;
            start33 = 1'b1;
            @(negedge clk);
            start33 = 1'b0;
            a33 = '0;
            b33 = '0;
            c0 = cyc;
            n = 0;
            while (!done33 && n < N33 + 6) begin
                @(negedge clk);
                n++;
            end
            chk("w33_done", 72'(done33), 72'(1));
            chk("w33_latency", 72'(cyc - c0), 72'(N33));
            chk("w33_product", 72'(product33), 72'(66'h3_FFFF_FFFC_0000_0001));
        end

        // Start held for 40 cycles.
        start_op($urandom, $urandom, 40, 1'b0);
        wait_done();

        // Start rising edge while busy.
        start_op($urandom, $urandom, 3, 1'b1);
        wait_done();

        // Back-to-back: product held in DONE until the next result lands.
        start_op(32'd7, 32'd6, 1, 1'b0);
        wait_done();
        repeat (2) @(negedge clk);
        chk("b2b_hold_product", 72'(product), 72'(42));
        chk("b2b_hold_done", 72'(done), 72'(1));
        start_op(32'd0, 32'hDEAD_BEEF, 1, 1'b0);
        chk("b2b_product_during_busy", 72'(product), 72'(42));
        wait_done();

        // Reset in the middle of an operation.
        start_op($urandom, $urandom, 1, 1'b0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_done", 72'(done), 72'(0));
        chk("midrst_busy", 72'(busy), 72'(0));
        chk("midrst_product", 72'(product), 72'(0));
        exp_q.delete();
        lat_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        start_op(32'd3, 32'd5, 1, 1'b0);
        wait_done();
        chk("post_rst_product", 72'(product), 72'(15));

        // Randomized operations.
        for (int t = 0; t < 20; t++) begin
            logic [31:0] av;
            logic [31:0] bv;
            av = $urandom;
            bv = $urandom;
            case ($urandom_range(0, 3))
                0: av = '0;
                1: bv = 32'hFFFF_FFFF;
                default: ;
            endcase
            start_op(av, bv, $urandom_range(1, 3), 1'($urandom_range(0, 1)));
            wait_done();
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 72'(exp_q.size()), 72'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
